// File: rtl/radix4_booth_mac_if.sv
// Operand/result bundle for radix4_booth_mac: operand pair with tags in, product and accumulator out.
interface radix4_booth_mac_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 24
);
  logic                     i_valid;
  logic signed [WIDTH-1:0]  i_x;
  logic signed [WIDTH-1:0]  i_y;
  logic                     i_first;
  logic                     i_last;
  logic                     o_valid;
  logic signed [2*WIDTH-1:0] o_prod;
  logic signed [ACC_W-1:0]  o_acc;
  logic                     o_acc_valid;
  logic                     o_ovf;

  modport master (
    output i_valid, i_x, i_y, i_first, i_last,
    input  o_valid, o_prod, o_acc, o_acc_valid, o_ovf
  );

  modport slave (
    input  i_valid, i_x, i_y, i_first, i_last,
    output o_valid, o_prod, o_acc, o_acc_valid, o_ovf
  );
endinterface

// File: rtl/radix4_booth_mac.sv
// Fully pipelined signed radix-4 Booth multiply-accumulate (latency WIDTH/2+2 to product).
// Define RADIX4_MAC_SAT_EN for a saturating accumulator with sticky o_ovf; default wraps.
module radix4_booth_mac #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  radix4_booth_mac_if.slave bus
);
  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned MW = WIDTH + 2;
  localparam int unsigned PW = 2 * WIDTH;

  // Digit codes: 001=+1, 010=+2, 111=-1, 110=-2, 000=0
  function automatic logic [2:0] booth_digit(input logic [2:0] t);
    logic [2:0] d;
    d = 3'b000;
    case (t)
      3'b001, 3'b010: d = 3'b001;
      3'b011:         d = 3'b010;
      3'b100:         d = 3'b110;
      3'b101, 3'b110: d = 3'b111;
      default:        d = 3'b000;
    endcase
    return d;
  endfunction

  function automatic logic signed [MW-1:0] booth_pp(
    input logic [2:0]           d,
    input logic signed [MW-1:0] px,
    input logic signed [MW-1:0] nx,
    input logic signed [MW-1:0] p2x,
    input logic signed [MW-1:0] n2x
  );
    logic signed [MW-1:0] r;
    r = '0;
    case (d)
      3'b001:  r = px;
      3'b010:  r = p2x;
      3'b111:  r = nx;
      3'b110:  r = n2x;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                    s1_valid, s1_first, s1_last;
  logic signed [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0]        s1_y;

  logic                 s2_valid, s2_first, s2_last;
  logic [2:0]           s2_dig [N];
  logic signed [MW-1:0] s2_px, s2_nx, s2_p2x, s2_n2x;

  logic                 p_valid [N];
  logic                 p_first [N];
  logic                 p_last  [N];
  logic signed [PW-1:0] p_sum   [N];
  logic [2:0]           p_dig   [N][N];
  logic signed [MW-1:0] p_px    [N];
  logic signed [MW-1:0] p_nx    [N];
  logic signed [MW-1:0] p_p2x   [N];
  logic signed [MW-1:0] p_n2x   [N];

  logic                 in_valid [N];
  logic                 in_first [N];
  logic                 in_last  [N];
  logic signed [PW-1:0] in_sum   [N];
  logic [2:0]           in_dig   [N][N];
  logic signed [MW-1:0] in_px    [N];
  logic signed [MW-1:0] in_nx    [N];
  logic signed [MW-1:0] in_p2x   [N];
  logic signed [MW-1:0] in_n2x   [N];

  logic [WIDTH:0]       yext_c;
  logic [2:0]           dig_c [N];
  logic signed [MW-1:0] xe_c;

  logic out_first, out_last;

  // Stage 1: input register; tags only meaningful with a valid term
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= bus.i_valid;
      s1_first <= bus.i_valid & bus.i_first;
      s1_last  <= bus.i_valid & bus.i_last;
      s1_x     <= bus.i_x;
      s1_y     <= bus.i_y;
    end
  end

  // Booth recoding with an implicit zero below the multiplier LSB
  always_comb begin
    yext_c = {s1_y, 1'b0};
    xe_c   = MW'(s1_x);
    for (int j = 0; j < N; j++) begin
      dig_c[j] = booth_digit(yext_c[2*j+2 -: 3]);
    end
  end

  // Stage 2: digits plus the four candidate multiples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_px    <= '0;
      s2_nx    <= '0;
      s2_p2x   <= '0;
      s2_n2x   <= '0;
      for (int j = 0; j < N; j++) s2_dig[j] <= 3'b000;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_px    <= xe_c;
      s2_nx    <= -xe_c;
      s2_p2x   <= xe_c <<< 1;
      s2_n2x   <= -(xe_c <<< 1);
      for (int j = 0; j < N; j++) s2_dig[j] <= dig_c[j];
    end
  end

  // Feed of each partial-product stage: stage 0 from stage 2, others from predecessor
  always_comb begin
    in_valid[0] = s2_valid;
    in_first[0] = s2_first;
    in_last[0]  = s2_last;
    in_sum[0]   = '0;
    in_dig[0]   = s2_dig;
    in_px[0]    = s2_px;
    in_nx[0]    = s2_nx;
    in_p2x[0]   = s2_p2x;
    in_n2x[0]   = s2_n2x;
    for (int j = 1; j < N; j++) begin
      in_valid[j] = p_valid[j-1];
      in_first[j] = p_first[j-1];
      in_last[j]  = p_last[j-1];
      in_sum[j]   = p_sum[j-1];
      in_dig[j]   = p_dig[j-1];
      in_px[j]    = p_px[j-1];
      in_nx[j]    = p_nx[j-1];
      in_p2x[j]   = p_p2x[j-1];
      in_n2x[j]   = p_n2x[j-1];
    end
  end

  // Stages 3..N+2: stage j adds digit j times x, weighted by 4^j (exact modulo 2^PW)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        p_valid[j] <= 1'b0;
        p_first[j] <= 1'b0;
        p_last[j]  <= 1'b0;
        p_sum[j]   <= '0;
        p_px[j]    <= '0;
        p_nx[j]    <= '0;
        p_p2x[j]   <= '0;
        p_n2x[j]   <= '0;
        for (int i = 0; i < N; i++) p_dig[j][i] <= 3'b000;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        p_valid[j] <= in_valid[j];
        p_first[j] <= in_first[j];
        p_last[j]  <= in_last[j];
        p_sum[j]   <= in_sum[j] + (PW'(booth_pp(in_dig[j][j], in_px[j], in_nx[j],
                                                in_p2x[j], in_n2x[j])) <<< (2 * j));
        p_dig[j]   <= in_dig[j];
        p_px[j]    <= in_px[j];
        p_nx[j]    <= in_nx[j];
        p_p2x[j]   <= in_p2x[j];
        p_n2x[j]   <= in_n2x[j];
      end
    end
  end

  // Product output register; o_prod holds across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_valid <= 1'b0;
      bus.o_prod  <= '0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      bus.o_valid <= p_valid[N-1];
      out_first   <= p_first[N-1];
      out_last    <= p_last[N-1];
      if (p_valid[N-1]) bus.o_prod <= p_sum[N-1];
    end
  end

  logic signed [ACC_W-1:0] prod_ext_c;
  logic signed [ACC_W-1:0] acc_sum_c;

  assign prod_ext_c = ACC_W'(bus.o_prod);

`ifdef RADIX4_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] wide_c;
  logic                  ovf_hit_c;

  // One guard bit exposes overflow; clamp toward the sign of the true sum
  always_comb begin
    wide_c    = (ACC_W+1)'(bus.o_acc) + (ACC_W+1)'(prod_ext_c);
    ovf_hit_c = wide_c[ACC_W] != wide_c[ACC_W-1];
    acc_sum_c = wide_c[ACC_W-1:0];
    if (ovf_hit_c) acc_sum_c = wide_c[ACC_W] ? ACC_MIN : ACC_MAX;
  end
`else
  assign acc_sum_c = bus.o_acc + prod_ext_c;
`endif

  // Accumulator: first-tagged term restarts the sum, bubbles leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_acc       <= '0;
      bus.o_acc_valid <= 1'b0;
      bus.o_ovf       <= 1'b0;
    end else begin
      bus.o_acc_valid <= bus.o_valid & out_last;
      if (bus.o_valid) bus.o_acc <= out_first ? prod_ext_c : acc_sum_c;
`ifdef RADIX4_MAC_SAT_EN
      if (bus.o_valid) begin
        if (out_first)      bus.o_ovf <= 1'b0;
        else if (ovf_hit_c) bus.o_ovf <= 1'b1;
      end
`else
      bus.o_ovf <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_radix4_booth_mac.sv
// Self-checking bench for radix4_booth_mac: three configurations (8/24, 8/16, 16/40)
// against an arithmetic model of product timing, accumulation and overflow.
module tb_radix4_booth_mac;
  localparam int DEPTH = 2048;
`ifdef RADIX4_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  radix4_booth_mac_if #(.WIDTH(8),  .ACC_W(24)) b8  ();
  radix4_booth_mac_if #(.WIDTH(8),  .ACC_W(16)) b8s ();
  radix4_booth_mac_if #(.WIDTH(16), .ACC_W(40)) b16 ();

  radix4_booth_mac #(.WIDTH(8),  .ACC_W(24)) u_a (.clk(clk), .rst_n(rst_n), .bus(b8));
  radix4_booth_mac #(.WIDTH(8),  .ACC_W(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(b8s));
  radix4_booth_mac #(.WIDTH(16), .ACC_W(40)) u_c (.clk(clk), .rst_n(rst_n), .bus(b16));

  typedef struct {
    longint x;
    longint y;
    bit     f;
    bit     l;
    longint prod;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int lat_m [3]  = '{6, 6, 10};
  int accw_m [3] = '{24, 16, 40};

  bit     exp_pv [3][DEPTH];
  longint exp_p  [3][DEPTH];
  bit     exp_au [3][DEPTH];
  longint exp_a  [3][DEPTH];
  bit     exp_o  [3][DEPTH];
  bit     exp_av [3][DEPTH];

  longint acc_m [3];
  bit     ovf_m [3];
  longint cur_p [3];
  longint cur_a [3];
  bit     cur_o [3];

  task automatic cmp(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic longint fit(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  // Schedule the effects of a term sampled at the next edge
  function automatic void push(input int d, input longint p, input bit f, input bit l);
    int     t;
    longint hi;
    longint lo;
    longint s;
    t  = cyc + 1 + lat_m[d];
    hi = (longint'(1) << (accw_m[d] - 1)) - 1;
    lo = -(longint'(1) << (accw_m[d] - 1));
    exp_pv[d][t] = 1'b1;
    exp_p[d][t]  = p;
    if (f) begin
      acc_m[d] = p;
      ovf_m[d] = 1'b0;
    end else begin
      s = acc_m[d] + p;
      if (SAT && s > hi) begin
        acc_m[d] = hi;
        ovf_m[d] = 1'b1;
      end else if (SAT && s < lo) begin
        acc_m[d] = lo;
        ovf_m[d] = 1'b1;
      end else begin
        acc_m[d] = fit(s, accw_m[d]);
      end
    end
    exp_au[d][t+1] = 1'b1;
    exp_a[d][t+1]  = acc_m[d];
    exp_o[d][t+1]  = ovf_m[d];
    exp_av[d][t+1] = l;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int c = cyc + 1; c < DEPTH; c++) begin
        exp_pv[d][c] = 1'b0;
        exp_au[d][c] = 1'b0;
        exp_av[d][c] = 1'b0;
      end
      acc_m[d] = 0;
      ovf_m[d] = 1'b0;
      cur_p[d] = 0;
      cur_a[d] = 0;
      cur_o[d] = 1'b0;
    end
  endfunction

  task automatic check_dut(input int d, input logic v, input longint p, input logic av,
                           input longint a, input logic o);
    if (exp_pv[d][cyc]) cur_p[d] = exp_p[d][cyc];
    if (exp_au[d][cyc]) begin
      cur_a[d] = exp_a[d][cyc];
      cur_o[d] = exp_o[d][cyc];
    end
    cmp($sformatf("dut%0d o_valid", d), longint'(v), longint'(exp_pv[d][cyc]));
    cmp($sformatf("dut%0d o_prod", d), p, cur_p[d]);
    cmp($sformatf("dut%0d o_acc_valid", d), longint'(av), longint'(exp_av[d][cyc]));
    cmp($sformatf("dut%0d o_acc", d), a, cur_a[d]);
    cmp($sformatf("dut%0d o_ovf", d), longint'(o), longint'(cur_o[d]));
  endtask

  task automatic check_all();
    check_dut(0, b8.o_valid,  longint'(b8.o_prod),  b8.o_acc_valid,  longint'(b8.o_acc),  b8.o_ovf);
    check_dut(1, b8s.o_valid, longint'(b8s.o_prod), b8s.o_acc_valid, longint'(b8s.o_acc), b8s.o_ovf);
    check_dut(2, b16.o_valid, longint'(b16.o_prod), b16.o_acc_valid, longint'(b16.o_acc), b16.o_ovf);
  endtask

  task automatic set_idle();
    b8.i_valid  = 1'b0; b8.i_first  = 1'b0; b8.i_last  = 1'b0; b8.i_x  = '0; b8.i_y  = '0;
    b8s.i_valid = 1'b0; b8s.i_first = 1'b0; b8s.i_last = 1'b0; b8s.i_x = '0; b8s.i_y = '0;
    b16.i_valid = 1'b0; b16.i_first = 1'b0; b16.i_last = 1'b0; b16.i_x = '0; b16.i_y = '0;
  endtask

  // Present one slot to dut d (others idle), advance one edge, check every output
  task automatic tick(input int d, input bit v, input longint x, input longint y,
                      input bit f, input bit l, input longint p);
    set_idle();
    case (d)
      0: begin b8.i_valid = v;  b8.i_x = 8'(x);   b8.i_y = 8'(y);   b8.i_first = f;  b8.i_last = l;  end
      1: begin b8s.i_valid = v; b8s.i_x = 8'(x);  b8s.i_y = 8'(y);  b8s.i_first = f; b8s.i_last = l; end
      default: begin b16.i_valid = v; b16.i_x = 16'(x); b16.i_y = 16'(y); b16.i_first = f; b16.i_last = l; end
    endcase
    if (v) push(d, p, f, l);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
  endtask

  vec_t tbl [8];
  longint first_sum;
  bit     seen;
  int     pulses;
  int     stray;
  longint rx, ry;

  initial begin
    tbl[0] = '{x: 1,    y: 4,    f: 1'b1, l: 1'b0, prod: 4};
    tbl[1] = '{x: 2,    y: 5,    f: 1'b0, l: 1'b0, prod: 10};
    tbl[2] = '{x: 3,    y: 6,    f: 1'b0, l: 1'b1, prod: 18};
    tbl[3] = '{x: -86,  y: 85,   f: 1'b1, l: 1'b0, prod: -7310};
    tbl[4] = '{x: 18,   y: -17,  f: 1'b0, l: 1'b0, prod: -306};
    tbl[5] = '{x: 127,  y: -128, f: 1'b0, l: 1'b0, prod: -16256};
    tbl[6] = '{x: -1,   y: -1,   f: 1'b0, l: 1'b1, prod: 1};
    tbl[7] = '{x: -128, y: 127,  f: 1'b1, l: 1'b1, prod: -16256};

    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset o_valid", longint'(b8.o_valid), 0);
    cmp("reset o_prod", longint'(b8.o_prod), 0);
    cmp("reset o_acc", longint'(b8.o_acc), 0);
    cmp("reset o_acc_valid", longint'(b8.o_acc_valid), 0);
    cmp("reset o_ovf", longint'(b8.o_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Most negative operand squared, single-term sum
    tick(0, 1'b1, -128, -128, 1'b1, 1'b1, 16384);
    idle(5);
    cmp("t1 o_valid before latency", longint'(b8.o_valid), 0);
    idle(1);
    cmp("t1 o_valid at latency", longint'(b8.o_valid), 1);
    cmp("t1 o_prod", longint'(b8.o_prod), 16384);
    idle(1);
    cmp("t1 o_acc_valid", longint'(b8.o_acc_valid), 1);
    cmp("t1 o_acc", longint'(b8.o_acc), 16384);
    idle(2);

    // Back-to-back table then 30 random mixed-sign terms
    seen = 1'b0;
    first_sum = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 1'b1, tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].l, tbl[i].prod);
      if (b8.o_acc_valid && !seen) begin seen = 1'b1; first_sum = longint'(b8.o_acc); end
    end
    for (int i = 0; i < 30; i++) begin
      rx = longint'($urandom_range(0, 255)) - 128;
      ry = longint'($urandom_range(0, 255)) - 128;
      tick(0, 1'b1, rx, ry, i == 0, i == 29, rx * ry);
      if (b8.o_acc_valid && !seen) begin seen = 1'b1; first_sum = longint'(b8.o_acc); end
    end
    idle(8);
    cmp("t2 first completed sum", first_sum, 32);

    // Same three terms with two-cycle bubbles
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1'b1, tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].l, tbl[i].prod);
      pulses += int'(b8.o_acc_valid);
      for (int b = 0; b < 2; b++) begin
        idle(1);
        pulses += int'(b8.o_acc_valid);
      end
    end
    for (int i = 0; i < 8; i++) begin
      idle(1);
      pulses += int'(b8.o_acc_valid);
    end
    cmp("t3 pulse count", longint'(pulses), 1);
    cmp("t3 o_acc", longint'(b8.o_acc), 32);

    // Reset with four terms in flight
    for (int i = 0; i < 4; i++) tick(0, 1'b1, 10 + i, -3, i == 0, i == 3, (10 + i) * -3);
    set_idle();
    rst_n = 1'b0;
    #1;
    cmp("t4 o_valid in reset", longint'(b8.o_valid), 0);
    cmp("t4 o_prod in reset", longint'(b8.o_prod), 0);
    cmp("t4 o_acc in reset", longint'(b8.o_acc), 0);
    cmp("t4 o_acc_valid in reset", longint'(b8.o_acc_valid), 0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      stray += int'(b8.o_valid) + int'(b8.o_acc_valid);
    end
    cmp("t4 stray outputs after reset", longint'(stray), 0);
    tick(0, 1'b1, 5, -7, 1'b1, 1'b1, -35);
    idle(5);
    cmp("t4 o_valid early", longint'(b8.o_valid), 0);
    idle(1);
    cmp("t4 o_prod after reset", longint'(b8.o_prod), -35);
    idle(2);

    // Narrow accumulator: wrap or saturate
    tick(1, 1'b1, 127, 127, 1'b1, 1'b0, 16129);
    tick(1, 1'b1, 127, 127, 1'b0, 1'b0, 16129);
    tick(1, 1'b1, 127, 127, 1'b0, 1'b1, 16129);
    idle(8);
    cmp("t5 o_acc", longint'(b8s.o_acc), SAT ? 32767 : -17149);
    cmp("t5 o_ovf", longint'(b8s.o_ovf), SAT ? 1 : 0);
    tick(1, 1'b1, 3, 3, 1'b1, 1'b1, 9);
    idle(8);
    cmp("t5 o_ovf after first", longint'(b8s.o_ovf), 0);
    cmp("t5 o_acc after first", longint'(b8s.o_acc), 9);

    // 16-bit operands, latency 10
    tick(2, 1'b1, -32768, -32768, 1'b1, 1'b0, 1073741824);
    idle(9);
    cmp("t6 o_valid early", longint'(b16.o_valid), 0);
    idle(1);
    cmp("t6 o_valid at latency", longint'(b16.o_valid), 1);
    cmp("t6 o_prod max", longint'(b16.o_prod), 1073741824);
    tick(2, 1'b1, 32767, -32768, 1'b0, 1'b1, -1073709056);
    idle(11);
    cmp("t6 o_prod mixed", longint'(b16.o_prod), -1073709056);
    cmp("t6 o_acc", longint'(b16.o_acc), 32768);

    // Random traffic on every configuration
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 100; i++) begin
        if (d == 2) begin
          rx = longint'($urandom_range(0, 65535)) - 32768;
          ry = longint'($urandom_range(0, 65535)) - 32768;
        end else begin
          rx = longint'($urandom_range(0, 255)) - 128;
          ry = longint'($urandom_range(0, 255)) - 128;
        end
        tick(d, $urandom_range(0, 3) != 0, rx, ry, $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0, rx * ry);
      end
      idle(12);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
